// File: rtl/display_state_sync_if.sv
// Update channel from the elevator controller into the display double buffer.
// The controller drives the master side; display_state_sync sits on the slave side.
interface display_state_sync_if #(
    parameter int NUM_FLOORS = 4,
    parameter int PEOPLE_W   = 4,
    parameter int STATE_W    = 3
);
    logic                           upd_valid;
    logic                           upd_ready;
    logic [STATE_W-1:0]             upd_state;
    logic [1:0]                     upd_dest;
    logic [NUM_FLOORS*PEOPLE_W-1:0] upd_people;

    modport master (
        output upd_valid,
        output upd_state,
        output upd_dest,
        output upd_people,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_state,
        input  upd_dest,
        input  upd_people,
        output upd_ready
    );
endinterface

// File: rtl/display_state_sync.sv
// Frame-synchronous double buffer: controller updates land in a shadow register and
// are committed to the pixel-generator view only at the start of vertical blanking.
module display_state_sync #(
    parameter int NUM_FLOORS   = 4,
    parameter int PEOPLE_W     = 4,
    parameter int STATE_W      = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic                           pixel_clk,
    input  logic                           reset,
    input  logic [9:0]                     horiz_count,
    input  logic [9:0]                     vert_count,
    display_state_sync_if.slave            upd,
    output logic [STATE_W-1:0]             sim_state,
    output logic [1:0]                     destination,
    output logic [NUM_FLOORS*PEOPLE_W-1:0] people_data,
    output logic [PEOPLE_W+1:0]            people_total,
    output logic                           blink,
    output logic                           commit_pulse,
    output logic                           dest_err
);
    localparam int PEOPLE_BITS = NUM_FLOORS * PEOPLE_W;
    localparam int TOTAL_W     = PEOPLE_W + 2;
    localparam int CNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]       H_VB       = 10'(H_ACTIVE);
    localparam logic [9:0]       V_VB       = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

    state_t                   state_reg, state_next;
    logic                     upd_ready_reg;
    logic [STATE_W-1:0]       shadow_state_reg;
    logic [1:0]               shadow_dest_reg;
    logic [PEOPLE_BITS-1:0]   shadow_people_reg;
    logic [STATE_W-1:0]       sim_state_reg;
    logic [1:0]               destination_reg;
    logic [PEOPLE_BITS-1:0]   people_data_reg;
    logic [TOTAL_W-1:0]       people_total_reg, people_total_next;
    logic [CNT_W-1:0]         frame_cnt_reg;
    logic                     blink_reg;
    logic                     commit_pulse_reg;
    logic                     dest_err_reg;
    logic [PEOPLE_W-1:0]      floor_count [NUM_FLOORS];

    logic vblank_start;
    logic accept;
    logic dest_bad;

    assign vblank_start = (vert_count == V_VB) && (horiz_count == H_VB);
    assign accept       = upd.upd_valid && upd_ready_reg;
    assign dest_bad     = (int'(upd.upd_dest) >= NUM_FLOORS);

    // FSM state register
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)       state_next = PENDING;
            PENDING: if (vblank_start) state_next = COMMIT;
            COMMIT:                    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign floor_count[gi] = shadow_people_reg[gi*PEOPLE_W +: PEOPLE_W];
        end
    endgenerate

    always_comb begin
        people_total_next = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            people_total_next = people_total_next + TOTAL_W'(floor_count[f]);
        end
    end

    // Ready follows the next state, so it is a clean register with no path from upd_valid.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            upd_ready_reg     <= 1'b1;
            shadow_state_reg  <= '0;
            shadow_dest_reg   <= '0;
            shadow_people_reg <= '0;
            sim_state_reg     <= '0;
            destination_reg   <= '0;
            people_data_reg   <= '0;
            people_total_reg  <= '0;
            commit_pulse_reg  <= 1'b0;
            dest_err_reg      <= 1'b0;
        end else begin
            upd_ready_reg    <= (state_next == IDLE);
            commit_pulse_reg <= (state_reg == COMMIT);
            dest_err_reg     <= accept && dest_bad;
            if (accept) begin
                shadow_state_reg  <= upd.upd_state;
                shadow_people_reg <= upd.upd_people;
                if (!dest_bad) begin
                    shadow_dest_reg <= upd.upd_dest;
                end
            end
            if (state_reg == COMMIT) begin
                sim_state_reg    <= shadow_state_reg;
                destination_reg  <= shadow_dest_reg;
                people_data_reg  <= shadow_people_reg;
                people_total_reg <= people_total_next;
            end
        end
    end

    // Blink phase runs on frame count alone, regardless of update traffic.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else if (vblank_start) begin
            if (frame_cnt_reg == FRAME_LAST) begin
                frame_cnt_reg <= '0;
                blink_reg     <= ~blink_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign upd.upd_ready  = upd_ready_reg;
    assign sim_state      = sim_state_reg;
    assign destination    = destination_reg;
    assign people_data    = people_data_reg;
    assign people_total   = people_total_reg;
    assign blink          = blink_reg;
    assign commit_pulse   = commit_pulse_reg;
    assign dest_err       = dest_err_reg;
endmodule

// File: tb/tb_display_state_sync.sv
// Directed bench for display_state_sync: a 4-floor instance for the main flow and blink,
// and a 3-floor instance for out-of-range destination handling.
module tb_display_state_sync;
    logic       pixel_clk = 1'b0;
    logic       reset;
    logic [9:0] horiz_count;
    logic [9:0] vert_count;

    logic [2:0]  sim_state_a,    sim_state_b;
    logic [1:0]  destination_a,  destination_b;
    logic [15:0] people_data_a;
    logic [11:0] people_data_b;
    logic [5:0]  people_total_a, people_total_b;
    logic        blink_a, blink_b, commit_pulse_a, commit_pulse_b, dest_err_a, dest_err_b;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cp_count = 0;
    int vb = 0;

    display_state_sync_if #(.NUM_FLOORS(4)) if_a ();
    display_state_sync_if #(.NUM_FLOORS(3)) if_b ();

    display_state_sync #(.NUM_FLOORS(4)) dut_a (
        .pixel_clk(pixel_clk), .reset(reset),
        .horiz_count(horiz_count), .vert_count(vert_count),
        .upd(if_a.slave),
        .sim_state(sim_state_a), .destination(destination_a),
        .people_data(people_data_a), .people_total(people_total_a),
        .blink(blink_a), .commit_pulse(commit_pulse_a), .dest_err(dest_err_a)
    );

    display_state_sync #(.NUM_FLOORS(3)) dut_b (
        .pixel_clk(pixel_clk), .reset(reset),
        .horiz_count(horiz_count), .vert_count(vert_count),
        .upd(if_b.slave),
        .sim_state(sim_state_b), .destination(destination_b),
        .people_data(people_data_b), .people_total(people_total_b),
        .blink(blink_b), .commit_pulse(commit_pulse_b), .dest_err(dest_err_b)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) begin
        if (commit_pulse_a) cp_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %s: got %0h expected %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // One compressed frame: a single vblank_start cycle then three active-area cycles.
    task automatic frame();
        horiz_count = 10'd640;
        vert_count  = 10'd480;
        tick();
        vb++;
        horiz_count = 10'd5;
        vert_count  = 10'd7;
        tick();
        if (vb == 29 || vb == 30 || vb == 31 || vb == 59 || vb == 60 || vb == 61)
            check($sformatf("blink_vb%0d", vb), 32'(blink_a), 32'((vb / 30) % 2));
        tick();
        tick();
    endtask

    task automatic offer_a(input logic [2:0] st, input logic [1:0] dst, input logic [15:0] ppl);
        if_a.upd_valid  = 1'b1;
        if_a.upd_state  = st;
        if_a.upd_dest   = dst;
        if_a.upd_people = ppl;
    endtask

    task automatic offer_b(input logic [2:0] st, input logic [1:0] dst, input logic [11:0] ppl);
        if_b.upd_valid  = 1'b1;
        if_b.upd_state  = st;
        if_b.upd_dest   = dst;
        if_b.upd_people = ppl;
    endtask

    initial begin
        reset = 1'b1;
        horiz_count = 10'd0;
        vert_count  = 10'd0;
        if_a.upd_valid = 1'b0; if_a.upd_state = '0; if_a.upd_dest = '0; if_a.upd_people = '0;
        if_b.upd_valid = 1'b0; if_b.upd_state = '0; if_b.upd_dest = '0; if_b.upd_people = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_state",  32'(sim_state_a),    32'd0);
        check("rst_dest",   32'(destination_a),  32'd0);
        check("rst_people", 32'(people_data_a),  32'd0);
        check("rst_total",  32'(people_total_a), 32'd0);
        check("rst_ready",  32'(if_a.upd_ready), 32'd1);
        check("rst_pulse",  32'(commit_pulse_a), 32'd0);
        check("rst_blink",  32'(blink_a),        32'd0);

        frame(); frame(); frame();
        check("idle_cp",    32'(cp_count),       32'd0);
        check("idle_ready", 32'(if_a.upd_ready), 32'd1);
        check("idle_blink", 32'(blink_a),        32'd0);

        // Basic update: accepted mid-frame, committed two edges after vblank_start.
        offer_a(3'd3, 2'd2, 16'h1234);
        tick();
        if_a.upd_valid = 1'b0;
        check("ready_drop", 32'(if_a.upd_ready), 32'd0);
        tick(); tick();
        check("hold_pre_vb", 32'(sim_state_a), 32'd0);
        horiz_count = 10'd640; vert_count = 10'd480;
        tick();
        vb++;
        horiz_count = 10'd5; vert_count = 10'd7;
        check("vb_edge1_state", 32'(sim_state_a),    32'd0);
        check("vb_edge1_pulse", 32'(commit_pulse_a), 32'd0);
        tick();
        check("c1_state",  32'(sim_state_a),    32'd3);
        check("c1_dest",   32'(destination_a),  32'd2);
        check("c1_people", 32'(people_data_a),  32'h1234);
        check("c1_total",  32'(people_total_a), 32'd10);
        check("c1_pulse",  32'(commit_pulse_a), 32'd1);
        check("c1_ready",  32'(if_a.upd_ready), 32'd1);
        tick();
        check("c1_pulse_end", 32'(commit_pulse_a), 32'd0);
        check("c1_cp",        32'(cp_count),       32'd1);

        // upd_valid held through PENDING with new data: second value waits for IDLE.
        offer_a(3'd5, 2'd1, 16'h2222);
        tick();
        offer_a(3'd6, 2'd3, 16'h0F0F);
        tick(); tick(); tick();
        check("held_ready", 32'(if_a.upd_ready), 32'd0);
        frame();
        if_a.upd_valid = 1'b0;
        check("hA_state",  32'(sim_state_a),    32'd5);
        check("hA_people", 32'(people_data_a),  32'h2222);
        check("hA_total",  32'(people_total_a), 32'd8);
        check("hB_taken",  32'(if_a.upd_ready), 32'd0);
        frame();
        check("hB_state",  32'(sim_state_a),    32'd6);
        check("hB_dest",   32'(destination_a),  32'd3);
        check("hB_people", 32'(people_data_a),  32'h0F0F);
        check("hB_total",  32'(people_total_a), 32'd30);
        check("hB_cp",     32'(cp_count),       32'd3);

        // Accept on the vblank_start cycle: commit slips to the following frame.
        offer_a(3'd1, 2'd0, 16'h0001);
        horiz_count = 10'd640; vert_count = 10'd480;
        tick();
        vb++;
        if_a.upd_valid = 1'b0;
        horiz_count = 10'd5; vert_count = 10'd7;
        tick(); tick();
        check("vbacc_cp",    32'(cp_count),    32'd3);
        check("vbacc_state", 32'(sim_state_a), 32'd6);
        frame();
        check("vbacc_c_state", 32'(sim_state_a),    32'd1);
        check("vbacc_c_total", 32'(people_total_a), 32'd1);
        check("vbacc_c_cp",    32'(cp_count),       32'd4);

        // Out-of-range destination on the 3-floor instance.
        offer_b(3'd2, 2'd1, 12'h321);
        tick();
        if_b.upd_valid = 1'b0;
        check("b_err_ok", 32'(dest_err_b), 32'd0);
        frame();
        check("b_dest1",  32'(destination_b),  32'd1);
        check("b_total1", 32'(people_total_b), 32'd6);
        offer_b(3'd4, 2'd3, 12'h111);
        tick();
        if_b.upd_valid = 1'b0;
        check("b_err_pulse", 32'(dest_err_b), 32'd1);
        tick();
        check("b_err_end", 32'(dest_err_b), 32'd0);
        frame();
        check("b_dest_kept", 32'(destination_b),  32'd1);
        check("b_state2",    32'(sim_state_b),    32'd4);
        check("b_people2",   32'(people_data_b),  32'h111);
        check("b_total2",    32'(people_total_b), 32'd3);

        // Blink: frames through vblank 61, blink checked around 30 and 60.
        while (vb < 61) frame();

        // Reset while PENDING discards the shadow.
        offer_a(3'd7, 2'd1, 16'hFFFF);
        tick();
        if_a.upd_valid = 1'b0;
        check("pend_ready", 32'(if_a.upd_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(sim_state_a),    32'd0);
        check("async_rst_ready", 32'(if_a.upd_ready), 32'd1);
        tick(); tick();
        reset = 1'b0;
        vb = 0;
        frame(); frame();
        check("prst_cp",     32'(cp_count),       32'd4);
        check("prst_state",  32'(sim_state_a),    32'd0);
        check("prst_people", 32'(people_data_a),  32'd0);
        check("prst_ready",  32'(if_a.upd_ready), 32'd1);
        check("prst_blink",  32'(blink_a),        32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
